// File: rtl/srl_fifo_pkg.sv
// Shared sizing constants and the occupancy update rule for the SRL16 FIFO.
package srl_fifo_pkg;

    localparam int SRL_DEPTH = 16;
    localparam int SRL_AW    = 4;
    localparam int LVL_W     = 5;

    function automatic logic [LVL_W-1:0] next_cnt(
        input logic [LVL_W-1:0] cnt,
        input logic             push,
        input logic             pop
    );
        logic [LVL_W-1:0] cnt_nxt;
        cnt_nxt = cnt;
        // A simultaneous push and pop leaves the count unchanged.
        case ({push, pop})
            2'b10:   cnt_nxt = cnt + LVL_W'(1);
            2'b01:   cnt_nxt = cnt - LVL_W'(1);
            default: cnt_nxt = cnt;
        endcase
        return cnt_nxt;
    endfunction

endpackage

// File: rtl/srlc16e.sv
// Behavioural model of the SRLC16E addressable shift register (cascade output not modelled).
module SRLC16E #(
    parameter logic [15:0] INIT            = 16'h0000,
    parameter logic [0:0]  IS_CLK_INVERTED = 1'b0
) (
    output logic Q,
    input  logic A0,
    input  logic A1,
    input  logic A2,
    input  logic A3,
    input  logic CE,
    input  logic CLK,
    input  logic D
);

    // NOTE: shift-register storage has no reset pin; only the power-up value is defined.
    logic [15:0] r_sr = INIT;
    logic [3:0]  w_addr;

    assign w_addr = {A3, A2, A1, A0};
    assign Q      = r_sr[w_addr];

    generate
        if (IS_CLK_INVERTED != 1'b0) begin : g_neg
            always_ff @(negedge CLK) begin
                if (CE) r_sr <= {r_sr[14:0], D};
            end
        end else begin : g_pos
            always_ff @(posedge CLK) begin
                if (CE) r_sr <= {r_sr[14:0], D};
            end
        end
    endgenerate

endmodule

// File: rtl/srl16_fifo.sv
// Valid/ready FIFO: SRLC16E column (16 words) plus a registered output stage, 17 words total.
module srl16_fifo
    import srl_fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int AFULL_LVL = 12
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              S_VALID,
    output logic              S_READY,
    input  logic [DATA_W-1:0] S_DATA,
    output logic              M_VALID,
    input  logic              M_READY,
    output logic [DATA_W-1:0] M_DATA,
    output logic [LVL_W-1:0]  LEVEL,
    output logic              AFULL
);

    logic [LVL_W-1:0]  r_cnt;
    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic [LVL_W-1:0]  r_level;
    logic              r_afull;

    logic              w_push;
    logic              w_pop;
    logic [SRL_AW-1:0] w_addr;
    logic [DATA_W-1:0] w_srl_q;
    logic [LVL_W-1:0]  w_cnt_nxt;
    logic              w_m_valid_nxt;
    logic [LVL_W-1:0]  w_level_nxt;

    assign S_READY = (r_cnt != LVL_W'(SRL_DEPTH));
    assign w_push  = S_VALID & S_READY;
    assign w_pop   = (r_cnt != '0) & (~r_m_valid | M_READY);

    // Oldest word sits at cnt-1; at cnt=16 the low nibble wraps 0 -> 15 as required.
    assign w_addr = (r_cnt == '0) ? '0 : (r_cnt[SRL_AW-1:0] - SRL_AW'(1));

    assign w_cnt_nxt     = next_cnt(r_cnt, w_push, w_pop);
    assign w_m_valid_nxt = w_pop | (r_m_valid & ~M_READY);
    assign w_level_nxt   = w_cnt_nxt + LVL_W'(w_m_valid_nxt);

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_srl
            SRLC16E #(
                .INIT            (16'h0000),
                .IS_CLK_INVERTED (1'b0)
            ) u_srl (
                .Q   (w_srl_q[gi]),
                .A0  (w_addr[0]),
                .A1  (w_addr[1]),
                .A2  (w_addr[2]),
                .A3  (w_addr[3]),
                .CE  (w_push),
                .CLK (CLK),
                .D   (S_DATA[gi])
            );
        end
    endgenerate

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt     <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_level   <= '0;
            r_afull   <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_m_valid <= w_m_valid_nxt;
            if (w_pop) r_m_data <= w_srl_q;
            r_level   <= w_level_nxt;
            r_afull   <= (w_level_nxt >= LVL_W'(AFULL_LVL));
        end
    end

    assign M_VALID = r_m_valid;
    assign M_DATA  = r_m_data;
    assign LEVEL   = r_level;
    assign AFULL   = r_afull;

endmodule
